// File: rtl/jtcontra_snd_pkg.sv
// Shared FSM state type and default sizing constants for the sound-command scheduler.
package jtcontra_snd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ARM,
    ST_WAIT,
    ST_GAP
  } snd_state_t;

  localparam int SND_DEPTH_AW = 2;
  localparam int SND_GAP      = 64;
  localparam int SND_TO_W     = 16;

endpackage

// File: rtl/jtcontra_snd_fifo.sv
// Small synchronous FIFO for queued sound commands; register-array storage,
// pointers wrap modulo 2^AW and count saturates at 2^AW (full).
module jtcontra_snd_fifo #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [7:0]    r_mem [2**AW];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  // A push into a full FIFO is legal only when a pop frees the head slot in the same cycle.
  assign w_pop  = pop  && !empty && !flush;
  assign w_push = push && !flush && (!full || w_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  assign dout  = r_mem[r_rd];
  assign full  = (r_cnt == DEPTH);
  assign empty = (r_cnt == '0);
  assign count = r_cnt;

endmodule

// File: rtl/jtcontra_sndcmd.sv
// Sound-command scheduler: queues main-CPU bytes and hands them to the sound CPU
// one at a time with IRQ/ack handshake and guard gap. Optional IRQ retrigger on
// missing ack is enabled by defining JTCONTRA_SNDCMD_TIMEOUT_EN.
module jtcontra_sndcmd
  import jtcontra_snd_pkg::*;
#(
  parameter int DEPTH_AW = SND_DEPTH_AW,
  parameter int GAP      = SND_GAP,
  parameter int TO_W     = SND_TO_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                main_wr,
  input  logic [7:0]          main_din,
  input  logic                flush,
  input  logic                snd_ack,
  output logic [7:0]          snd_latch,
  output logic                snd_irq,
  output logic                full,
  output logic [DEPTH_AW:0]   pending,
  output logic                ovf
);

  localparam logic [7:0] GAP_LAST = 8'(GAP - 1);

  if (GAP < 1 || GAP > 255 || TO_W < 1 || DEPTH_AW < 1) begin : g_bad_param
    $error("jtcontra_sndcmd: parameter out of range");
  end

  snd_state_t          r_state;
  logic [7:0]          r_latch;
  logic [7:0]          r_gap;
  logic                r_irq;
  logic                r_ovf;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
  logic [TO_W-1:0]     r_to;
`endif

  logic                w_pop;
  logic                w_push;
  logic                w_empty;
  logic                w_full;
  logic [7:0]          w_head;
  logic [DEPTH_AW:0]   w_count;

  assign w_pop  = (r_state == ST_LOAD) && !flush;
  assign w_push = main_wr && !flush && (!w_full || w_pop);

  jtcontra_snd_fifo #(.AW(DEPTH_AW)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_push),
    .pop   (w_pop),
    .flush (flush),
    .din   (main_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_latch <= 8'h00;
      r_gap   <= '0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
      r_to    <= '0;
`endif
    end else if (flush) begin
      // The latch keeps its byte; only the handshake and queue are abandoned.
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (main_wr && w_full && !w_pop) r_ovf <= 1'b1;
      case (r_state)
        ST_IDLE: if (!w_empty) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_latch <= w_head;
          r_state <= ST_ARM;
        end
        ST_ARM: begin
          r_irq   <= 1'b1;
          r_state <= ST_WAIT;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
          r_to    <= '0;
`endif
        end
        ST_WAIT: begin
          if (snd_ack) begin
            r_irq   <= 1'b0;
            r_gap   <= '0;
            r_state <= ST_GAP;
          end
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
          else begin
            // On wrap the IRQ drops for one cycle, giving the sound CPU a fresh edge.
            r_to  <= r_to + 1'b1;
            r_irq <= ~&r_to;
          end
`endif
        end
        ST_GAP: begin
          if (r_gap == GAP_LAST) r_state <= w_empty ? ST_IDLE : ST_LOAD;
          else                   r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign snd_latch = r_latch;
  assign snd_irq   = r_irq;
  assign full      = w_full;
  assign pending   = w_count;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_jtcontra_sndcmd.sv
// Scoreboard bench for jtcontra_sndcmd: stimulus queues expected latch bytes,
// a negedge monitor checks each new IRQ presentation and the post-ack gap.
module tb_jtcontra_sndcmd;

  localparam int GAP = 64;
`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
  localparam int TO_W = 4;
`else
  localparam int TO_W = 16;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       main_wr;
  logic [7:0] main_din;
  logic       flush;
  logic       snd_ack;
  logic [7:0] snd_latch;
  logic       snd_irq;
  logic       full;
  logic [2:0] pending;
  logic       ovf;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  jtcontra_sndcmd #(.DEPTH_AW(2), .GAP(GAP), .TO_W(TO_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .main_wr   (main_wr),
    .main_din  (main_din),
    .flush     (flush),
    .snd_ack   (snd_ack),
    .snd_latch (snd_latch),
    .snd_irq   (snd_irq),
    .full      (full),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit accept);
    main_din = b;
    main_wr  = 1'b1;
    if (accept) exp_q.push_back(b);
    tick();
    main_wr  = 1'b0;
  endtask

  task automatic ack_pulse();
    snd_ack = 1'b1;
    tick();
    snd_ack = 1'b0;
  endtask

  task automatic wait_irq();
    int n = 0;
    while (!snd_irq && n < 400) begin
      tick();
      n++;
    end
    check("irq_wait", snd_irq, 1'b1);
  endtask

  task automatic drain(input int k);
    for (int i = 0; i < k; i++) begin
      wait_irq();
      repeat (2) tick();
      ack_pulse();
    end
    repeat (GAP + 2) tick();
  endtask

  // Monitor: one scoreboard pop per fresh IRQ presentation.
  int         cyc = 0;
  int         ack_cyc = 0;
  bit         ack_valid = 0;
  bit         armed = 0;
  logic [7:0] prev_latch = 8'h00;
  logic       prev_irq = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rstn || flush) begin
      armed     = 0;
      ack_valid = 0;
    end else begin
      if (snd_latch !== prev_latch && ack_valid) begin
        check("gap_spacing_ok", ((cyc - ack_cyc) >= GAP + 1), 1'b1);
        ack_valid = 0;
      end
      if (snd_irq && !prev_irq && !armed) begin
        check("latch_setup", snd_latch, prev_latch);
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else                   check("latch_value", snd_latch, exp_q.pop_front());
        armed = 1;
      end
      if (snd_ack && snd_irq) begin
        armed     = 0;
        ack_cyc   = cyc;
        ack_valid = 1;
      end
    end
    prev_latch = snd_latch;
    prev_irq   = snd_irq;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; main_wr = 1'b0; main_din = 8'h00; flush = 1'b0; snd_ack = 1'b0;
    repeat (3) tick();
    check("rst_latch", snd_latch, 8'h00);
    check("rst_irq", snd_irq, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_pending", pending, 3'd0);
    check("rst_ovf", ovf, 1'b0);
    rstn = 1'b1;
    repeat (2) tick();

    // Single command latency: latch at edge 2, IRQ at edge 3.
    wr(8'h5A, 1);
    check("t1_pending", pending, 3'd1);
    tick();
    check("t1_latch_e1", snd_latch, 8'h00);
    check("t1_irq_e1", snd_irq, 1'b0);
    tick();
    check("t1_latch_e2", snd_latch, 8'h5A);
    check("t1_irq_e2", snd_irq, 1'b0);
    tick();
    check("t1_irq_e3", snd_irq, 1'b1);
    repeat (10) tick();
    ack_pulse();
    check("t1_irq_ack", snd_irq, 1'b0);
    repeat (GAP) tick();
    check("t1_irq_idle", snd_irq, 1'b0);
    check("t1_pending_idle", pending, 3'd0);

    // Ack while idle must be ignored.
    ack_pulse();
    repeat (3) tick();
    check("idle_ack_irq", snd_irq, 1'b0);
    check("idle_ack_latch", snd_latch, 8'h5A);

    // Burst of five on consecutive cycles: one to the latch, four queued.
    for (int i = 1; i <= 5; i++) wr(8'(i), 1);
    check("burst_ovf", ovf, 1'b0);
    check("burst_pending", pending, 3'd4);
    check("burst_full", full, 1'b1);
    drain(5);
    check("burst_done_pending", pending, 3'd0);

    // Overflow while waiting for ack.
    wr(8'hAA, 1);
    wait_irq();
    wr(8'hB1, 1); wr(8'hB2, 1); wr(8'hB3, 1); wr(8'hB4, 1);
    check("ovf_pre", ovf, 1'b0);
    wr(8'hEE, 0);
    check("ovf_set", ovf, 1'b1);
    check("ovf_pending", pending, 3'd4);
    check("ovf_full", full, 1'b1);
    drain(5);
    check("ovf_sticky", ovf, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ovf_flush_clr", ovf, 1'b0);
    repeat (2) tick();

    // Write into a full FIFO during the LOAD cycle is accepted.
    wr(8'hC0, 1);
    wait_irq();
    wr(8'hC1, 1); wr(8'hC2, 1); wr(8'hC3, 1); wr(8'hC4, 1);
    check("sim_full_pre", full, 1'b1);
    ack_pulse();
    repeat (GAP) tick();
    wr(8'hC5, 1);
    check("sim_ovf", ovf, 1'b0);
    check("sim_pending", pending, 3'd4);
    check("sim_latch", snd_latch, 8'hC1);
    drain(5);

    // Flush while waiting with three pending.
    wr(8'hD0, 1);
    wait_irq();
    wr(8'hD1, 1); wr(8'hD2, 1); wr(8'hD3, 1);
    check("fl_pending_pre", pending, 3'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_irq", snd_irq, 1'b0);
    check("fl_pending", pending, 3'd0);
    check("fl_latch", snd_latch, 8'hD0);
    check("fl_sb", exp_q.size(), 3);
    exp_q.delete();
    repeat (5) tick();
    check("fl_idle_irq", snd_irq, 1'b0);

`ifdef JTCONTRA_SNDCMD_TIMEOUT_EN
    // No ack: one-cycle IRQ low every 16 WAIT cycles, latch constant.
    wr(8'hF0, 1);
    wait_irq();
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("to_irq", snd_irq, (i % 16) != 0);
    end
    check("to_latch", snd_latch, 8'hF0);
    ack_pulse();
    repeat (GAP + 2) tick();
`endif

    // Asynchronous reset in the middle of the guard gap.
    wr(8'hE0, 1);
    wait_irq();
    wr(8'hE1, 1);
    ack_pulse();
    repeat (5) tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_latch", snd_latch, 8'h00);
    check("arst_irq", snd_irq, 1'b0);
    check("arst_pending", pending, 3'd0);
    check("arst_full", full, 1'b0);
    check("arst_ovf", ovf, 1'b0);
    exp_q.delete();
    repeat (2) tick();
    rstn = 1'b1;
    repeat (2) tick();

    wr(8'h77, 1);
    drain(1);
    check("sb_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
